// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states, result-bus width
// and the ready/start strobe levels used by the EX stage.
package div_unit_pkg;

   localparam int DIV_WIDTH    = 32;
   localparam int DivResultBus = 2 * DIV_WIDTH;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it is non-negative.
import div_unit_pkg::*;

module div_step #(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             dvd_bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             quo_bit_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // rem_i < divisor_i always holds, so bit WIDTH of diff is a clean sign bit.
   assign shifted   = {rem_i, dvd_bit_i};
   assign diff      = shifted - {1'b0, divisor_i};
   assign quo_bit_o = ~diff[WIDTH];
   assign rem_o     = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU with EX stall request.
// Optional macro DIV_EARLY_OUT_EN: finish at acceptance when |divisor| > |dividend|.
import div_unit_pkg::*;

module div_unit #(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               stallreq_o
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   div_state_e         state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   dvd_q;
   logic [WIDTH-1:0]   dvs_q;
   logic               dvd_neg_q;
   logic               quo_neg_q;
   logic [2*WIDTH-1:0] result_q;
   logic               ready_q;

   logic               op1_neg_d;
   logic               op2_neg_d;
   logic [WIDTH-1:0]   op1_mag_d;
   logic [WIDTH-1:0]   op2_mag_d;
   logic [WIDTH-1:0]   step_rem_d;
   logic               step_quo_d;
   logic [WIDTH-1:0]   quo_raw_d;
   logic [WIDTH-1:0]   quo_fix_d;
   logic [WIDTH-1:0]   rem_fix_d;

   assign op1_neg_d = signed_div_i & opdata1_i[WIDTH-1];
   assign op2_neg_d = signed_div_i & opdata2_i[WIDTH-1];
   assign op1_mag_d = op1_neg_d ? -opdata1_i : opdata1_i;
   assign op2_mag_d = op2_neg_d ? -opdata2_i : opdata2_i;

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_i     (rem_q),
      .dvd_bit_i (dvd_q[WIDTH-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem_d),
      .quo_bit_o (step_quo_d)
   );

   // dvd_q shifts the dividend out at the top and collects quotient bits at the
   // bottom, so after the last step it holds the unsigned quotient.
   assign quo_raw_d = {dvd_q[WIDTH-2:0], step_quo_d};
   assign quo_fix_d = quo_neg_q ? -quo_raw_d : quo_raw_d;
   assign rem_fix_d = dvd_neg_q ? -step_rem_d : step_rem_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DivFree;
         cnt_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         dvd_neg_q <= 1'b0;
         quo_neg_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= DivResultNotReady;
      end else begin
         case (state_q)
            DivFree: begin
               if (start_i == DivStart && !annul_i) begin
                  dvd_neg_q <= op1_neg_d;
                  quo_neg_q <= op1_neg_d ^ op2_neg_d;
                  dvd_q     <= op1_mag_d;
                  dvs_q     <= op2_mag_d;
                  rem_q     <= '0;
                  cnt_q     <= '0;
                  if (op2_mag_d == '0) begin
                     state_q <= DivByZero;
`ifdef DIV_EARLY_OUT_EN
                  end else if (op2_mag_d > op1_mag_d) begin
                     state_q  <= DivEnd;
                     result_q <= {opdata1_i, {WIDTH{1'b0}}};
                     ready_q  <= DivResultReady;
`endif
                  end else begin
                     state_q <= DivOn;
                  end
               end
            end
            DivByZero: begin
               if (annul_i) begin
                  state_q <= DivFree;
               end else begin
                  state_q  <= DivEnd;
                  result_q <= '0;
                  ready_q  <= DivResultReady;
               end
            end
            DivOn: begin
               if (annul_i) begin
                  state_q <= DivFree;
               end else begin
                  rem_q <= step_rem_d;
                  dvd_q <= quo_raw_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_STEP) begin
                     state_q  <= DivEnd;
                     result_q <= {rem_fix_d, quo_fix_d};
                     ready_q  <= DivResultReady;
                  end
               end
            end
            DivEnd: begin
               if (annul_i || start_i == DivStop) begin
                  state_q <= DivFree;
                  ready_q <= DivResultNotReady;
               end
            end
            default: begin
               state_q <= DivFree;
               ready_q <= DivResultNotReady;
            end
         endcase
      end
   end

   assign result_o   = result_q;
   assign ready_o    = ready_q;
   assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; edge counts below include the
// acceptance edge, so a full divide reports 33, divide-by-zero 2, early-out 1.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        stallreq;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef DIV_EARLY_OUT_EN
   localparam int EO_N = 1;
`else
   localparam int EO_N = 33;
`endif

   always #5 clk = ~clk;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready),
      .stallreq_o   (stallreq)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b);
      signed_div = s;
      op1        = a;
      op2        = b;
      annul      = 1'b0;
      start      = 1'b1;
   endtask

   // Counts edges from the acceptance edge up to the one that raises ready_o.
   task automatic wait_ready(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!ready && n < 40);
   endtask

   task automatic release_op();
      start = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      n_cmp++;
      if (result !== 64'h0) begin
         n_bad++; $display("FAIL reset_result: got %h expected %h", result, 64'h0);
      end
      n_cmp++;
      if (ready !== 1'b0) begin
         n_bad++; $display("FAIL reset_ready: got %b expected 0", ready);
      end
      n_cmp++;
      if (stallreq !== 1'b0) begin
         n_bad++; $display("FAIL reset_stallreq: got %b expected 0", stallreq);
      end
      $display("reset: result=%h ready=%b stallreq=%b", result, ready, stallreq);
   endtask

   task automatic test_divu_basic();
      int n;
      int stall_bad;
      drive(1'b0, 32'd100, 32'd7);
      #1;
      n_cmp++;
      if (stallreq !== 1'b1) begin
         n_bad++; $display("FAIL divu_stall_first: got %b expected 1", stallreq);
      end
      n = 0;
      stall_bad = 0;
      do begin
         tick();
         n++;
         if (!ready && stallreq !== 1'b1) stall_bad++;
      end while (!ready && n < 40);
      $display("divu 100/7: result=%h edges=%0d", result, n);
      n_cmp++;
      if (n !== 33) begin
         n_bad++; $display("FAIL divu_latency: got %0d expected 33", n);
      end
      n_cmp++;
      if (result !== 64'h00000002_0000000E) begin
         n_bad++; $display("FAIL divu_result: got %h expected %h", result, 64'h00000002_0000000E);
      end
      n_cmp++;
      if (stall_bad !== 0) begin
         n_bad++; $display("FAIL divu_stall_busy: got %0d low cycles expected 0", stall_bad);
      end
      n_cmp++;
      if (stallreq !== 1'b0) begin
         n_bad++; $display("FAIL divu_stall_ready: got %b expected 0", stallreq);
      end
      repeat (3) tick();
      n_cmp++;
      if (ready !== 1'b1 || result !== 64'h00000002_0000000E) begin
         n_bad++; $display("FAIL divu_hold: got ready=%b result=%h expected ready=1 result=%h",
                           ready, result, 64'h00000002_0000000E);
      end
      release_op();
      n_cmp++;
      if (ready !== 1'b0) begin
         n_bad++; $display("FAIL divu_release: got %b expected 0", ready);
      end
   endtask

   task automatic test_signed_table();
      logic        s_t [6];
      logic [31:0] a_t [6];
      logic [31:0] b_t [6];
      logic [63:0] r_t [6];
      int          n_t [6];
      int          n;
      s_t[0] = 1'b1; a_t[0] = 32'hFFFFFFF9; b_t[0] = 32'd2;        r_t[0] = 64'hFFFFFFFF_FFFFFFFD; n_t[0] = 33;
      s_t[1] = 1'b0; a_t[1] = 32'hFFFFFFF9; b_t[1] = 32'd2;        r_t[1] = 64'h00000001_7FFFFFFC; n_t[1] = 33;
      s_t[2] = 1'b1; a_t[2] = 32'd7;        b_t[2] = 32'hFFFFFFFE; r_t[2] = 64'h00000001_FFFFFFFD; n_t[2] = 33;
      s_t[3] = 1'b1; a_t[3] = 32'h80000000; b_t[3] = 32'hFFFFFFFF; r_t[3] = 64'h00000000_80000000; n_t[3] = 33;
      s_t[4] = 1'b1; a_t[4] = 32'h12345678; b_t[4] = 32'h0;        r_t[4] = 64'h0;                 n_t[4] = 2;
      s_t[5] = 1'b0; a_t[5] = 32'hFFFFFFFF; b_t[5] = 32'h0;        r_t[5] = 64'h0;                 n_t[5] = 2;
      for (int i = 0; i < 6; i++) begin
         drive(s_t[i], a_t[i], b_t[i]);
         wait_ready(n);
         $display("div s=%b %h/%h: result=%h edges=%0d", s_t[i], a_t[i], b_t[i], result, n);
         n_cmp++;
         if (n !== n_t[i]) begin
            n_bad++; $display("FAIL table%0d_latency: got %0d expected %0d", i, n, n_t[i]);
         end
         n_cmp++;
         if (result !== r_t[i]) begin
            n_bad++; $display("FAIL table%0d_result: got %h expected %h", i, result, r_t[i]);
         end
         release_op();
      end
   endtask

   task automatic test_annul();
      int n;
      int rises;
      drive(1'b0, 32'd1000, 32'd3);
      tick();
      repeat (9) tick();
      annul = 1'b1;
      tick();
      n_cmp++;
      if (ready !== 1'b0) begin
         n_bad++; $display("FAIL annul_ready: got %b expected 0", ready);
      end
      start = 1'b0;
      annul = 1'b0;
      rises = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ready) rises++;
      end
      $display("annul 1000/3: ready seen %0d cycles after flush", rises);
      n_cmp++;
      if (rises !== 0) begin
         n_bad++; $display("FAIL annul_no_ready: got %0d ready cycles expected 0", rises);
      end
      drive(1'b0, 32'd20, 32'd4);
      wait_ready(n);
      $display("divu 20/4: result=%h edges=%0d", result, n);
      n_cmp++;
      if (n !== 33 || result !== 64'h00000000_00000005) begin
         n_bad++; $display("FAIL annul_next_op: got edges=%0d result=%h expected edges=33 result=%h",
                           n, result, 64'h00000000_00000005);
      end
      annul = 1'b1;
      tick();
      n_cmp++;
      if (ready !== 1'b0) begin
         n_bad++; $display("FAIL annul_in_end: got %b expected 0", ready);
      end
      annul = 1'b0;
      start = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_op();
      int n;
      drive(1'b1, 32'hFFFFFF9C, 32'd7);
      tick();
      repeat (5) tick();
      rst   = 1'b1;
      start = 1'b0;
      tick();
      rst = 1'b0;
      $display("reset mid-op: result=%h ready=%b stallreq=%b", result, ready, stallreq);
      n_cmp++;
      if (result !== 64'h0 || ready !== 1'b0 || stallreq !== 1'b0) begin
         n_bad++; $display("FAIL rst_mid_on: got result=%h ready=%b stall=%b expected all 0",
                           result, ready, stallreq);
      end
      drive(1'b0, 32'd50, 32'd5);
      wait_ready(n);
      $display("divu 50/5: result=%h edges=%0d", result, n);
      n_cmp++;
      if (n !== 33 || result !== 64'h00000000_0000000A) begin
         n_bad++; $display("FAIL rst_then_op: got edges=%0d result=%h expected edges=33 result=%h",
                           n, result, 64'h00000000_0000000A);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      // Previous divide is sitting in END; dropping start returns to FREE.
      release_op();
      n_cmp++;
      if (ready !== 1'b0) begin
         n_bad++; $display("FAIL b2b_drop: got %b expected 0", ready);
      end
      drive(1'b1, 32'hFFFFFFF0, 32'd5);
      wait_ready(n);
      $display("div fffffff0/5: result=%h edges=%0d", result, n);
      n_cmp++;
      if (n !== 33 || result !== 64'hFFFFFFFF_FFFFFFFD) begin
         n_bad++; $display("FAIL b2b_op: got edges=%0d result=%h expected edges=33 result=%h",
                           n, result, 64'hFFFFFFFF_FFFFFFFD);
      end
      release_op();
   endtask

   task automatic test_early_out();
      logic        s_t [3];
      logic [31:0] a_t [3];
      logic [31:0] b_t [3];
      logic [63:0] r_t [3];
      int          n;
      s_t[0] = 1'b0; a_t[0] = 32'd3;        b_t[0] = 32'd10;       r_t[0] = 64'h00000003_00000000;
      s_t[1] = 1'b1; a_t[1] = 32'hFFFFFFFD; b_t[1] = 32'd10;       r_t[1] = 64'hFFFFFFFD_00000000;
      s_t[2] = 1'b0; a_t[2] = 32'hFFFFFFF9; b_t[2] = 32'hFFFFFFFA; r_t[2] = 64'hFFFFFFF9_00000000;
      for (int i = 0; i < 3; i++) begin
         drive(s_t[i], a_t[i], b_t[i]);
         wait_ready(n);
         $display("small quotient s=%b %h/%h: result=%h edges=%0d", s_t[i], a_t[i], b_t[i], result, n);
         n_cmp++;
         if (n !== EO_N) begin
            n_bad++; $display("FAIL early%0d_latency: got %0d expected %0d", i, n, EO_N);
         end
         n_cmp++;
         if (result !== r_t[i]) begin
            n_bad++; $display("FAIL early%0d_result: got %h expected %h", i, result, r_t[i]);
         end
         release_op();
      end
   endtask

   initial begin
      rst        = 1'b1;
      signed_div = 1'b0;
      op1        = '0;
      op2        = '0;
      start      = 1'b0;
      annul      = 1'b0;
      test_reset();
      test_divu_basic();
      test_signed_table();
      test_annul();
      test_reset_mid_op();
      test_back_to_back();
      test_early_out();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
